// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: states, opcodes,
// instruction classes, ALUOp and datapath mux-select codes.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_LUI    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD,
        C_STORE,
        C_RTYPE,
        C_ITYPE,
        C_BRANCH,
        C_JAL,
        C_LUI,
        C_ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_opcode_decode.sv
// Combinational opcode classifier feeding the control sequencer's DECODE dispatch.
module multicycle_control_fsm_opcode_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = C_ILLEGAL;
        case (opcode)
            OP_LOAD:   instr_class = C_LOAD;
            OP_STORE:  instr_class = C_STORE;
            OP_RTYPE:  instr_class = C_RTYPE;
            OP_ITYPE:  instr_class = C_ITYPE;
            OP_BRANCH: instr_class = C_BRANCH;
            OP_JAL:    instr_class = C_JAL;
            OP_LUI:    instr_class = C_LUI;
            default:   instr_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core with retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to park unknown opcodes in a sticky TRAP state.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal_instr
`endif
);

    state_t       state;
    state_t       next_state;
    instr_class_t instr_class;
    ctrl_t        ctrl;
    ctrl_t        ctrl_out;
    logic         retire;

    multicycle_control_fsm_opcode_decode u_opcode_decode (
        .opcode      (opcode),
        .instr_class (instr_class)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRC_A_PC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    next_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute oldPC+imm so branch/jal targets sit in ALUOut
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (instr_class)
                    C_LOAD, C_STORE: next_state = S_MEMADR;
                    C_RTYPE:         next_state = S_EXEC_R;
                    C_ITYPE:         next_state = S_EXEC_I;
                    C_BRANCH:        next_state = S_BRANCH;
                    C_JAL:           next_state = S_JAL;
                    C_LUI:           next_state = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:         next_state = S_TRAP;
`else
                    default:         next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                next_state     = (instr_class == C_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEMDATA;
                next_state      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALUOP_RTYPE;
                next_state     = S_ALUWB;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                next_state      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRC_A_RS1;
                ctrl.alu_src_b  = SRC_B_RS2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = branch_taken;
                next_state      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE target while the ALU forms oldPC+4 for rd
                ctrl.alu_src_a  = SRC_A_OLDPC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
                next_state      = S_ALUWB;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRC_A_ZERO;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                next_state     = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                next_state = S_TRAP;
            end
`endif
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    assign retire = (next_state == S_FETCH) && (state != S_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 1'b1;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_instr <= 1'b0;
        end else if (next_state == S_TRAP) begin
            illegal_instr <= 1'b1;
        end
    end
`endif

    // Reset forces FETCH, whose controls would otherwise request memory
    assign ctrl_out   = rst ? '0 : ctrl;
    assign mem_req    = ctrl_out.mem_req;
    assign mem_we     = ctrl_out.mem_we;
    assign iord       = ctrl_out.iord;
    assign ir_write   = ctrl_out.ir_write;
    assign pc_write   = ctrl_out.pc_write;
    assign reg_write  = ctrl_out.reg_write;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign result_src = ctrl_out.result_src;
    assign ALUOp      = ctrl_out.alu_op;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction cycle model,
// vector table, reset/trap sequences and randomized instruction streams.
module tb_multicycle_control_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = '0;
    logic          branch_taken = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, result_src, ALUOp;
    logic [3:0]    state_o;
    logic [CW-1:0] instret;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic          illegal_instr;
`endif

    multicycle_control_fsm #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .result_src   (result_src),
        .ALUOp        (ALUOp),
        .state_o      (state_o),
        .instret      (instret)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
        logic [1:0] a, b, rs, alu;
        logic [3:0] st;
    } obs_t;

    typedef struct {
        logic mr;
        logic bt;
        obs_t exp;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         fw;
        int         mw;
        int         lat;
        string      name;
    } vec_t;

    cyc_t cq[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   model_cnt = 0;
    int   busy = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t o(input int st, input int mq, input int we, input int io,
                               input int irw, input int pcw, input int rw,
                               input int a, input int b, input int rs, input int alu);
        obs_t r;
        r.mem_req = 1'(mq);  r.mem_we = 1'(we);    r.iord = 1'(io);
        r.ir_write = 1'(irw); r.pc_write = 1'(pcw); r.reg_write = 1'(rw);
        r.a = 2'(a); r.b = 2'(b); r.rs = 2'(rs); r.alu = 2'(alu); r.st = 4'(st);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t r;
        r = {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, result_src, ALUOp, state_o};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic mr, input logic bt, input obs_t e);
        cyc_t c;
        c.mr = mr; c.bt = bt; c.exp = e;
        cq.push_back(c);
    endtask

    // Cycle-by-cycle expectation of one instruction, from its class and wait counts
    task automatic model_instr(input logic [6:0] op, input logic bt, input int fw,
                               input int mw, output bit retires);
        obs_t aluwb;
        aluwb = o(8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        retires = 1'b1;
        for (int i = 0; i < fw; i++) push(1'b0, rb(), o(0, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0));
        push(1'b1, rb(), o(0, 1, 0, 0, 1, 1, 0, 0, 2, 2, 0));
        push(rb(), rb(), o(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        case (op)
            7'b0000011: begin
                push(rb(), rb(), o(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                for (int i = 0; i < mw; i++) push(1'b0, rb(), o(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                push(1'b1, rb(), o(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                push(rb(), rb(), o(4, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
            end
            7'b0100011: begin
                push(rb(), rb(), o(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                for (int i = 0; i < mw; i++) push(1'b0, rb(), o(5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
                push(1'b1, rb(), o(5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            7'b0110011: begin
                push(rb(), rb(), o(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2));
                push(rb(), rb(), aluwb);
            end
            7'b0010011: begin
                push(rb(), rb(), o(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 3));
                push(rb(), rb(), aluwb);
            end
            7'b1100011: push(rb(), bt, o(9, 0, 0, 0, 0, int'(bt), 0, 2, 0, 0, 1));
            7'b1101111: begin
                push(rb(), rb(), o(10, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0));
                push(rb(), rb(), aluwb);
            end
            7'b0110111: begin
                push(rb(), rb(), o(11, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
                push(rb(), rb(), aluwb);
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                retires = 1'b0;
`endif
            end
        endcase
    endtask

    task automatic step(input cyc_t c, input string name);
        mem_ready = c.mr;
        branch_taken = c.bt;
        @(negedge clk);
        check(name, 32'(dut_obs()), 32'(c.exp));
        if (state_o != 4'd0) busy++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic bt, input int fw,
                             input int mw, input string name);
        bit   ret;
        cyc_t c;
        opcode = op;
        busy = 0;
        model_instr(op, bt, fw, mw, ret);
        while (cq.size() > 0) begin
            c = cq.pop_front();
            step(c, name);
        end
        if (ret) model_cnt = (model_cnt + 1) % (1 << CW);
        check({name, "_instret"}, 32'(instret), 32'(model_cnt));
    endtask

    task automatic add_vec(input logic [6:0] op, input logic bt, input int fw,
                           input int mw, input int lat, input string name);
        vec_t v;
        v.op = op; v.bt = bt; v.fw = fw; v.mw = mw; v.lat = lat; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] legal_ops [7];
        logic [6:0] op;
        bit         ret;
        cyc_t       c;

        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1100011, 7'b1101111, 7'b0110111};

        add_vec(7'b0110011, 1'b0, 0, 0, 4, "add");
        add_vec(7'b0010011, 1'b0, 1, 0, 5, "addi_fw1");
        add_vec(7'b0000011, 1'b0, 0, 3, 8, "lw_w3");
        add_vec(7'b0000011, 1'b0, 0, 0, 5, "lw_w0");
        add_vec(7'b0100011, 1'b0, 0, 2, 6, "sw_w2");
        add_vec(7'b1100011, 1'b0, 0, 0, 3, "beq_nt");
        add_vec(7'b1100011, 1'b1, 0, 0, 3, "beq_t");
        add_vec(7'b1101111, 1'b0, 0, 0, 4, "jal");
        add_vec(7'b0110111, 1'b0, 0, 0, 4, "lui");
`ifndef CTRL_ILLEGAL_TRAP_EN
        add_vec(7'b1111111, 1'b0, 0, 0, 2, "illegal_nop");
`endif

        rst = 1'b1;
        mem_ready = 1'b1;
        branch_taken = 1'b1;
        opcode = 7'b0110011;
        #12;
        check("reset_outputs", 32'(dut_obs()), 32'd0);
        check("reset_instret", 32'(instret), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("reset_illegal", 32'(illegal_instr), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].bt, tbl[i].fw, tbl[i].mw, tbl[i].name);
            check({tbl[i].name, "_lat"}, 32'(busy + tbl[i].fw + 1), 32'(tbl[i].lat));
        end

        // Store stalled in MEMWR, then reset asserted mid-wait
        opcode = 7'b0100011;
        model_instr(7'b0100011, 1'b0, 0, 5, ret);
        for (int k = 0; k < 5; k++) begin
            c = cq.pop_front();
            step(c, "sw_pre_rst");
        end
        cq.delete();
        check("pre_rst_instret", 32'(instret), 32'(model_cnt));
        mem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 32'(dut_obs()), 32'd0);
        check("rst_mid_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        run_instr(7'b0110011, 1'b0, 0, 0, "add_after_rst");

        for (int n = 0; n < 60; n++) begin
            op = legal_ops[$urandom_range(0, 6)];
`ifndef CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
`endif
            run_instr(op, rb(), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_instr(7'b1111111, 1'b0, 0, 0, "illegal_enter");
        for (int k = 0; k < 4; k++) begin
            c.mr = rb();
            c.bt = rb();
            c.exp = o(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step(c, "trap_hold");
            check("trap_flag", 32'(illegal_instr), 32'd1);
            check("trap_instret", 32'(instret), 32'(model_cnt));
        end
        #2;
        rst = 1'b1;
        #1;
        check("trap_rst_flag", 32'(illegal_instr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        run_instr(7'b0110011, 1'b0, 0, 0, "add_after_trap");
`else
        run_instr(7'b1111111, 1'b0, 1, 0, "illegal_nop_fw1");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
